// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding and parameter defaults.
package uart_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam logic [7:0] HDR_BASE_DEF   = 8'hA0;
    localparam int         WORD_BYTES_DEF = 32;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or above the pointer wins, else the lowest overall.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic             hi_vld_s;
    logic [IDX_W-1:0] hi_idx_s;
    logic [IDX_W-1:0] lo_idx_s;

    // Descending scan so the last hit is the lowest qualifying index.
    always_comb begin
        hi_vld_s = 1'b0;
        hi_idx_s = '0;
        lo_idx_s = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            lo_idx_s = req_i[i] ? IDX_W'(i) : lo_idx_s;
            hi_idx_s = (req_i[i] && (IDX_W'(i) >= ptr_i)) ? IDX_W'(i) : hi_idx_s;
            hi_vld_s = hi_vld_s | (req_i[i] && (IDX_W'(i) >= ptr_i));
        end
    end

    always_comb begin
        valid_o = |req_i;
        idx_o   = hi_vld_s ? hi_idx_s : lo_idx_s;
        grant_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_o[i] = valid_o && (idx_o == IDX_W'(i));
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Serialises requester words into header/data byte frames for a shared UART transmitter.
// Define TX_CHECKSUM_EN to append an XOR checksum byte to every frame.
module uart_tx_scheduler
    import uart_tx_scheduler_pkg::*;
#(
    parameter int         NUM_REQ    = 2,
    parameter int         WORD_BYTES = WORD_BYTES_DEF,
    parameter logic [7:0] HDR_BASE   = HDR_BASE_DEF
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*WORD_BYTES*8-1:0] data,
    output logic [NUM_REQ-1:0]              ack,
    output logic                            busy,
    output logic                            tx_avail,
    output logic [7:0]                      tx_byte,
    input  logic                            tx_active,
    input  logic                            tx_done
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int BI_W   = $clog2(WORD_BYTES + 2);
    localparam int WORD_W = WORD_BYTES * 8;
`ifdef TX_CHECKSUM_EN
    localparam int FRAME_LEN = WORD_BYTES + 2;
`else
    localparam int FRAME_LEN = WORD_BYTES + 1;
`endif
    localparam logic [BI_W-1:0] LAST_IDX = BI_W'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    gidx_q, gidx_d;
    logic [WORD_W-1:0]   snap_q, snap_d;
    logic [BI_W-1:0]     bidx_q, bidx_d;
    logic                tx_avail_q, tx_avail_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d;

    logic [NUM_REQ-1:0]  arb_grant_s;
    logic [IDX_W-1:0]    arb_idx_s;
    logic                arb_valid_s;
    logic [WORD_W-1:0]   data_sel_s;
    logic [NUM_REQ-1:0]  gidx_oh_s;
    logic [7:0]          frame_byte_s;
    logic [7:0]          tail_byte_s;
    logic                issue_fire_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    assign issue_fire_s = (state_q == ST_ISSUE) && !tx_active;

`ifdef TX_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    // Running XOR of every byte issued so far in the frame.
    always_comb begin
        csum_d = issue_fire_s ? (csum_q ^ frame_byte_s) : csum_q;
        csum_d = (state_q == ST_IDLE) ? 8'h00 : csum_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign tail_byte_s = csum_q;
`else
    assign tail_byte_s = 8'h00;
`endif

    always_comb begin
        data_sel_s = '0;
        gidx_oh_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            data_sel_s   = arb_grant_s[i] ? data[i*WORD_W +: WORD_W] : data_sel_s;
            gidx_oh_s[i] = (gidx_q == IDX_W'(i));
        end
    end

    // Frame byte at the current index: header, data LSB-first, then tail (checksum).
    always_comb begin
        frame_byte_s = tail_byte_s;
        for (int k = 0; k < WORD_BYTES; k++) begin
            frame_byte_s = (bidx_q == BI_W'(k + 1)) ? snap_q[k*8 +: 8] : frame_byte_s;
        end
        frame_byte_s = (bidx_q == '0) ? (HDR_BASE | 8'(gidx_q)) : frame_byte_s;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gidx_d     = gidx_q;
        snap_d     = snap_q;
        bidx_d     = bidx_q;
        tx_byte_d  = tx_byte_q;
        tx_avail_d = 1'b0;
        ack_d      = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid_s) begin
                    gidx_d  = arb_idx_s;
                    snap_d  = data_sel_s;
                    bidx_d  = '0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (issue_fire_s) begin
                    tx_byte_d  = frame_byte_s;
                    tx_avail_d = 1'b1;
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (tx_done && (bidx_q == LAST_IDX)) begin
                    ack_d   = gidx_oh_s;
                    state_d = ST_ACK;
                end else if (tx_done) begin
                    bidx_d  = bidx_q + BI_W'(1);
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACK: begin
                ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : (gidx_q + IDX_W'(1));
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            gidx_q     <= '0;
            snap_q     <= '0;
            bidx_q     <= '0;
            tx_avail_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gidx_q     <= gidx_d;
            snap_q     <= snap_d;
            bidx_q     <= bidx_d;
            tx_avail_q <= tx_avail_d;
            tx_byte_q  <= tx_byte_d;
            ack_q      <= ack_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign tx_avail = tx_avail_q;
    assign tx_byte  = tx_byte_q;
    assign ack      = ack_q;

endmodule
